// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver: FSM state codes,
// parity modes, the per-frame configuration record and parity helpers.
package uart_pkg;

  localparam int DATA_WIDTH = 8;

  typedef logic [2:0] state_e;
  localparam state_e S_IDLE   = 3'b000;
  localparam state_e S_START  = 3'b001;
  localparam state_e S_DATA   = 3'b010;
  localparam state_e S_STOP   = 3'b011;
  localparam state_e S_DONE   = 3'b100;
  localparam state_e S_PARITY = 3'b101;

  // Encoding 3 is not listed and behaves as NONE.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef struct packed {
    parity_e parity;
    logic    two_stop;
  } config_st;

  function automatic logic parity_on(input parity_e p);
    return (p == EVEN) || (p == ODD);
  endfunction

  function automatic logic parity_expect(input parity_e p, input logic data_xor);
    return (p == ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load a value, count to zero and hold there;
// tick_o is high whenever the count has reached zero.
module uart_bit_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tick_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign tick_o = (count_q == '0);

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time divider/parity/stop-bit configuration and a
// single-word ready/valid output holding the data plus its error flags.
module uart_rx_cfg #(
  parameter int DATA_WIDTH  = uart_pkg::DATA_WIDTH,
  parameter int DIV_WIDTH   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);
  import uart_pkg::*;

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Handshake: the word and flags are presented while rx_valid is high and
  // stay stable until a cycle with rx_valid & rx_ready, where they are consumed.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  state_e                 state_q, state_d;
  config_st               cfg_q, cfg_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d, div_eff;
  logic [DATA_WIDTH-1:0]  data_q, data_d, rx_data_q, rx_data_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                   armed_q, armed_d;
  logic                   rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                   timer_load, tick;
  logic [DIV_WIDTH-1:0]   timer_val;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign div_eff = (clk_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : clk_div;

  uart_bit_timer #(.W(DIV_WIDTH)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .tick_o     (tick)
  );

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    div_d        = div_q;
    data_d       = data_q;
    bit_idx_d    = bit_idx_q;
    stop_cnt_d   = stop_cnt_q;
    par_err_d    = par_err_q;
    frm_err_d    = frm_err_q;
    armed_d      = armed_q | rx_s;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    timer_load   = 1'b0;
    timer_val    = div_q - 1'b1;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (armed_q && !rx_s) begin
          state_d    = S_START;
          cfg_d      = '{parity: parity_e'(parity_mode), two_stop: two_stop};
          div_d      = div_eff;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
          timer_load = 1'b1;
          timer_val  = (div_eff >> 1) - 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          timer_load = 1'b1;
          bit_idx_d  = '0;
          state_d    = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          timer_load        = 1'b1;
          data_d[bit_idx_q] = rx_s;
          stop_cnt_d        = 1'b0;
          if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            state_d = parity_on(cfg_q.parity) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          timer_load = 1'b1;
          if (rx_s != parity_expect(cfg_q.parity, ^data_q)) par_err_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          timer_load = 1'b1;
          // A low stop bit may be a break; re-arm only once the line is high again.
          if (!rx_s) begin
            frm_err_d = 1'b1;
            armed_d   = 1'b0;
          end
          if (cfg_q.two_stop && !stop_cnt_q) stop_cnt_d = 1'b1;
          else                               state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!rx_valid_q || rx_ready) begin
          rx_data_d    = data_q;
          parity_err_d = par_err_q;
          frame_err_d  = frm_err_q;
          rx_valid_d   = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '1;
      state_q      <= S_IDLE;
      cfg_q        <= '{parity: NONE, two_stop: 1'b0};
      div_q        <= DIV_WIDTH'(4);
      data_q       <= '0;
      bit_idx_q    <= '0;
      stop_cnt_q   <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      armed_q      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], rx};
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      div_q        <= div_d;
      data_q       <= data_d;
      bit_idx_q    <= bit_idx_d;
      stop_cnt_q   <= stop_cnt_d;
      par_err_q    <= par_err_d;
      frm_err_q    <= frm_err_d;
      armed_q      <= armed_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: serial frames driven bit by bit, expected
// words queued as {parity_err, frame_err, data} and checked on each handshake.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [11:0] clk_div = 12'd16;
  logic [1:0]  parity_mode = 2'd0;
  logic        two_stop = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic        parity_err, frame_err, overrun, busy;

  int          errors = 0;
  int          checks = 0;
  int          pop_cnt = 0;
  logic [9:0]  exp_q[$];

  uart_rx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(12), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .clk_div     (clk_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare every accepted word against the queue head
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'd1, 32'd0);
      end else begin
        check("word", {22'd0, parity_err, frame_err, rx_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int div, input int par_bit,
                            input logic s1, input logic s2, input bit two);
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(d[i], div);
    if (par_bit >= 0) drive_bit(par_bit[0], div);
    drive_bit(s1, div);
    if (two) drive_bit(s2, div);
    drive_bit(1'b1, 2 * div);
  endtask

  task automatic wait_pops(input int target, input int budget);
    int k = 0;
    while (pop_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("pop_count", pop_cnt, target);
  endtask

  initial begin
    bit seen_busy;
    int base;

    // reset
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_data", rx_data, 8'h00);
    check("reset_flags", {parity_err, frame_err, overrun}, 3'b000);
    check("reset_busy", busy, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // 8N1 0xA5
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    send_frame(8'hA5, 16, -1, 1'b1, 1'b1, 1'b0);
    wait_pops(1, 100);

    // EVEN parity with wrong parity bit, then ODD with matching bit
    parity_mode = 2'd1;
    exp_q.push_back({1'b1, 1'b0, 8'h03});
    send_frame(8'h03, 16, 1, 1'b1, 1'b1, 1'b0);
    wait_pops(2, 100);
    parity_mode = 2'd2;
    exp_q.push_back({1'b0, 1'b0, 8'h03});
    send_frame(8'h03, 16, 1, 1'b1, 1'b1, 1'b0);
    wait_pops(3, 100);
    parity_mode = 2'd3;
    exp_q.push_back({1'b0, 1'b0, 8'hC4});
    send_frame(8'hC4, 16, -1, 1'b1, 1'b1, 1'b0);
    wait_pops(4, 100);

    // two stop bits, second one low
    parity_mode = 2'd0;
    two_stop    = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 8'h5A});
    send_frame(8'h5A, 16, -1, 1'b1, 1'b0, 1'b1);
    wait_pops(5, 100);
    two_stop = 1'b0;

    // false start: 4-cycle low glitch
    base      = pop_cnt;
    seen_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) rx = 1'b1;
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      @(posedge clk);
      #1;
    end
    check("glitch_busy_seen", seen_busy, 1'b1);
    check("glitch_busy_end", busy, 1'b0);
    check("glitch_no_word", pop_cnt, base);

    // line break: frame_err with zero data, no restart while low
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    drive_bit(1'b0, 16 * 14);
    drive_bit(1'b1, 40);
    wait_pops(6, 10);
    check("break_idle", busy, 1'b0);

    // divider below the minimum behaves as 4
    clk_div = 12'd2;
    exp_q.push_back({1'b0, 1'b0, 8'h96});
    send_frame(8'h96, 4, -1, 1'b1, 1'b1, 1'b0);
    wait_pops(7, 100);
    clk_div = 12'd16;

    // overrun: second word dropped while the first is held
    rx_ready = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    send_frame(8'h11, 16, -1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 16, -1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_flag", overrun, 1'b1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    check("ovr_pop_count", pop_cnt, 8);
    check("ovr_valid_clr", rx_valid, 1'b0);
    check("ovr_flag_clr", overrun, 1'b0);
    rx_ready = 1'b1;

    // reset in the middle of the data bits of 0x77
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", rx_valid, 1'b0);
    drive_bit(1'b1, 40);
    exp_q.push_back({1'b0, 1'b0, 8'h3C});
    send_frame(8'h3C, 16, -1, 1'b1, 1'b1, 1'b0);
    wait_pops(9, 100);
    repeat (20) @(posedge clk);
    #1;
    check("final_pop_count", pop_cnt, 9);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
